spi_ram_arbiter: RTL and testbench
==================================

Name: spi_ram_arbiter

Overview:
- Owns the single-port 256x8 RAM and shares it between two requesters:
  - the SPI slave command path (10-bit rx_data words in, tx_data byte out);
  - a local host port (req/gnt handshake).
- Decodes the SPI 2-bit command field, holds address registers, arbitrates round-robin under contention and returns read data to the right requester.
- Sits between the SPI deserializer/serializer pair and a plain synchronous RAM macro.

Parameters:
- ADDR_SIZE, 8, RAM address width.
- MEM_DEPTH, 256, RAM depth; must equal 2**ADDR_SIZE.
- DATA_W, 8, RAM data width; rx_data width is DATA_W+2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  DATA_W+2  SPI word: [9:8] command, [7:0] address or data.
- rx_valid  in  1  single-cycle strobe, rx_data valid.
- tx_data  out  DATA_W  SPI read-return byte.
- tx_valid  out  1  single-cycle strobe, tx_data valid.
- spi_ovf  out  1  sticky: SPI memory command dropped.
- host_req  in  1  host access request, level.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_SIZE  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  single-cycle: host op issued to RAM.
- host_rdata  out  DATA_W  host read data.
- host_rvalid  out  1  single-cycle strobe, host_rdata valid.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_SIZE  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE; wr_addr, rd_addr, spi pending slot, spi_ovf and last_owner cleared.
  - last_owner reset value is HOST, so SPI wins the first contention.
  - Reset mid-operation aborts the op: no mem_en, tx_valid or host_rvalid after the reset cycle.
- SPI decode on rx_valid:
  - 00: wr_addr <= rx_data[7:0]; no RAM access.
  - 10: rd_addr <= rx_data[7:0]; no RAM access.
  - 01: queue write {addr=wr_addr, data=rx_data[7:0]}.
  - 11: queue read {addr=rd_addr}; rx_data[7:0] is ignored.
  - Queued ops snapshot the address at acceptance, so later 00/10 commands do not alter a pending op.
- SPI pending slot (depth 1):
  - 01/11 arriving while the slot is full and not issuing this cycle: command dropped, spi_ovf <= 1. spi_ovf is cleared only by rst.
  - Slot freeing in ISSUE and a new 01/11 arriving in the same cycle: the new command is accepted, no overflow.
- FSM:
  - IDLE:
    - Neither SPI slot nor host_req set: stay.
    - Exactly one requester: select it.
    - Both: select the one that is not last_owner.
    - On select, next state is ISSUE; the selected op is registered onto mem_*; last_owner is updated.
  - ISSUE (1 cycle):
    - mem_en = 1, mem_we/mem_addr/mem_wdata = selected op.
    - host_gnt = 1 if owner is HOST; SPI slot cleared if owner is SPI.
    - Next state is RESP on a read, IDLE on a write.
  - RESP (1 cycle):
    - Capture mem_rdata into tx_data (SPI) or host_rdata (HOST).
    - The matching valid pulses high in the following cycle.
    - Next state IDLE.
- mem_en is 0 outside ISSUE. mem_* hold their last values when idle.
- Latency from rx_valid (cycle T) for an 11 command with no contention:
  - T+1 slot full;
  - T+2 ISSUE;
  - T+3 RESP;
  - T+4 tx_valid=1.
- Host latency:
  - ISSUE in the cycle after host_req is seen in IDLE.
  - host_rvalid 2 cycles after host_gnt.
- Host rules:
  - Hold host_req/we/addr/wdata stable until host_gnt.
  - Drop host_req in the cycle after host_gnt, unless issuing a new request.
- Throughput: write 2 cycles per op, read 3 cycles per op.
- Address registers wrap naturally at ADDR_SIZE bits; no saturation.

Decomposition:
- Package spi_ram_pkg:
  - command localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - FSM state enum {IDLE, ISSUE, RESP};
  - owner enum {SPI, HOST}.
- One natural sub-module, spi_cmd_decoder: address registers, pending slot and overflow flag.
- Arbitration and FSM stay in the top level.

Test Plan:
- SPI write then read:
  - Send 0x0_3C, 0x1_A5, 0x2_3C, 0x3_00.
  - Expect RAM[0x3C]=0xA5 and tx_data=0xA5 with tx_valid exactly 4 cycles after the last rx_valid.
- Host write/read:
  - Host writes 0x10 <- 0x5A, then reads 0x10.
  - Expect host_gnt 1 cycle after req and host_rdata=0x5A, host_rvalid 2 cycles after the second gnt.
- Contention:
  - SPI 11 and host_req pending in the same IDLE cycle after reset.
  - SPI granted first, host next.
  - Repeat contention: host first (alternation).
- Overflow:
  - Hold host_req continuously with host last_owner; send two 01 commands back-to-back.
  - Second dropped, spi_ovf=1; RAM receives only the first data byte.
- Address snapshot:
  - Queue 01 with wr_addr=0x20 while the host is busy, then send 00 to 0x40 before issue.
  - Write lands at 0x20.
- Reset mid-read:
  - Assert rst during RESP.
  - No tx_valid afterwards; all outputs 0 and spi_ovf=0 the cycle after reset.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared constants for the SPI/host RAM arbiter.
//   - SPI command field encodings (rx_data[DATA_W+1:DATA_W])
//   - arbiter FSM state encodings
//   - requester (owner) encodings
package spi_ram_pkg;

  // SPI command field
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;  // load write address
  localparam logic [1:0] CMD_WR_DATA = 2'b01;  // queue write at wr_addr
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;  // load read address
  localparam logic [1:0] CMD_RD_DATA = 2'b11;  // queue read at rd_addr

  // Arbiter FSM states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_RESP  = 2'd2;

  // Requester that owns the RAM for the current operation
  typedef logic owner_t;
  localparam owner_t OWNER_SPI  = 1'b0;
  localparam owner_t OWNER_HOST = 1'b1;

endpackage

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: decodes SPI command words, keeps the write/read address
// registers and a one-entry pending slot for SPI memory operations.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rx_data         {cmd[1:0], payload[DATA_W-1:0]}
//   rx_valid        single-cycle strobe, rx_data valid
//   slot_clear      the arbiter is issuing the pending slot this cycle
//   slot_valid      a memory op is pending
//   slot_we         pending op is a write
//   slot_addr       address snapshotted when the op was accepted
//   slot_wdata      write data of the pending op
//   spi_ovf         sticky: a memory command arrived while the slot was full
module spi_cmd_decoder
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W+1:0]    rx_data,
  input  logic                 rx_valid,
  input  logic                 slot_clear,
  output logic                 slot_valid,
  output logic                 slot_we,
  output logic [ADDR_SIZE-1:0] slot_addr,
  output logic [DATA_W-1:0]    slot_wdata,
  output logic                 spi_ovf
);

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 slot_valid_q, slot_valid_d;
  logic                 slot_we_q, slot_we_d;
  logic [ADDR_SIZE-1:0] slot_addr_q, slot_addr_d;
  logic [DATA_W-1:0]    slot_wdata_q, slot_wdata_d;
  logic                 ovf_q, ovf_d;

  logic [1:0]           cmd;
  logic [DATA_W-1:0]    payload;

  assign cmd     = rx_data[DATA_W+1:DATA_W];
  assign payload = rx_data[DATA_W-1:0];

  always_comb begin
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    slot_valid_d = slot_valid_q;
    slot_we_d    = slot_we_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    ovf_d        = ovf_q;

    if (slot_clear) begin
      slot_valid_d = 1'b0;
    end

    if (rx_valid) begin
      case (cmd)
        CMD_WR_ADDR: wr_addr_d = payload[ADDR_SIZE-1:0];
        CMD_RD_ADDR: rd_addr_d = payload[ADDR_SIZE-1:0];
        default: begin
          // A slot being issued this cycle counts as free, so back-to-back
          // commands that line up with the issue are not lost.
          if (slot_valid_q && !slot_clear) begin
            ovf_d = 1'b1;
          end else begin
            slot_valid_d = 1'b1;
            slot_we_d    = (cmd == CMD_WR_DATA);
            // Address is captured now; later 00/10 commands leave it alone.
            slot_addr_d  = (cmd == CMD_WR_DATA) ? wr_addr_q : rd_addr_q;
            slot_wdata_d = payload;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      slot_valid_q <= 1'b0;
      slot_we_q    <= 1'b0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
      ovf_q        <= 1'b0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      slot_valid_q <= slot_valid_d;
      slot_we_q    <= slot_we_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      ovf_q        <= ovf_d;
    end
  end

  assign slot_valid = slot_valid_q;
  assign slot_we    = slot_we_q;
  assign slot_addr  = slot_addr_q;
  assign slot_wdata = slot_wdata_q;
  assign spi_ovf    = ovf_q;

endmodule

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: shares a single-port synchronous RAM between the SPI
// command path and a local host port, with round-robin arbitration.
//
// Handshakes: rx_valid is a one-cycle strobe with no backpressure (overflow
// drops the command and sets spi_ovf). host_req is a level held stable with
// we/addr/wdata until the one-cycle host_gnt; the request is consumed in the
// gnt cycle. tx_valid and host_rvalid are one-cycle strobes qualifying
// tx_data and host_rdata.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   rx_data, rx_valid              SPI command word in
//   tx_data, tx_valid              SPI read-return byte out
//   spi_ovf                        sticky SPI command drop flag
//   host_req/we/addr/wdata         host request
//   host_gnt                       host op issued to the RAM this cycle
//   host_rdata, host_rvalid        host read return
//   mem_en/we/addr/wdata           RAM control out
//   mem_rdata                      RAM read data, valid the cycle after a read
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256,
  parameter int DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W+1:0]    rx_data,
  input  logic                 rx_valid,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_valid,
  output logic                 spi_ovf,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [DATA_W-1:0]    host_wdata,
  output logic                 host_gnt,
  output logic [DATA_W-1:0]    host_rdata,
  output logic                 host_rvalid,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata
);

  if (MEM_DEPTH != (1 << ADDR_SIZE)) begin : g_bad_depth
    $error("MEM_DEPTH must equal 2**ADDR_SIZE");
  end

  state_t               state_q, state_d;
  owner_t               last_owner_q, last_owner_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]    tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0]    host_rdata_q, host_rdata_d;
  logic                 host_rvalid_q, host_rvalid_d;

  logic                 slot_valid;
  logic                 slot_we;
  logic [ADDR_SIZE-1:0] slot_addr;
  logic [DATA_W-1:0]    slot_wdata;
  logic                 slot_clear;
  logic                 pick_spi;

  spi_cmd_decoder #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_W    (DATA_W)
  ) u_dec (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .slot_clear (slot_clear),
    .slot_valid (slot_valid),
    .slot_we    (slot_we),
    .slot_addr  (slot_addr),
    .slot_wdata (slot_wdata),
    .spi_ovf    (spi_ovf)
  );

  // last_owner_q doubles as the owner of the op in ISSUE/RESP.
  assign slot_clear = (state_q == ST_ISSUE) && (last_owner_q == OWNER_SPI);

  // Round-robin: under contention the requester that went last yields.
  assign pick_spi = slot_valid && (!host_req || (last_owner_q == OWNER_HOST));

  always_comb begin
    state_d       = state_q;
    last_owner_d  = last_owner_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = 1'b0;
    host_rdata_d  = host_rdata_q;
    host_rvalid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_spi) begin
          state_d      = ST_ISSUE;
          last_owner_d = OWNER_SPI;
          mem_we_d     = slot_we;
          mem_addr_d   = slot_addr;
          mem_wdata_d  = slot_wdata;
        end else if (host_req) begin
          state_d      = ST_ISSUE;
          last_owner_d = OWNER_HOST;
          mem_we_d     = host_we;
          mem_addr_d   = host_addr;
          mem_wdata_d  = host_wdata;
        end
      end
      ST_ISSUE: begin
        state_d = mem_we_q ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (last_owner_q == OWNER_SPI) begin
          tx_data_d  = mem_rdata;
          tx_valid_d = 1'b1;
        end else begin
          host_rdata_d  = mem_rdata;
          host_rvalid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_owner_q  <= OWNER_HOST;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_owner_q  <= last_owner_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign mem_en      = (state_q == ST_ISSUE);
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign host_gnt    = (state_q == ST_ISSUE) && (last_owner_q == OWNER_HOST);
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: directed bench for spi_ram_arbiter with a behavioural
// 256x8 synchronous RAM and expected-value queues for read returns.
module tb_spi_ram_arbiter;

  logic       clk;
  logic       rst;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       spi_ovf;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_host_q[$];

  logic [7:0] ram [256];

  spi_ram_arbiter #(
    .ADDR_SIZE (8),
    .MEM_DEPTH (256),
    .DATA_W    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .spi_ovf     (spi_ovf),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {26'd0, tx_data, tx_valid, spi_ovf, host_gnt, host_rdata, host_rvalid,
            mem_en, mem_we, mem_addr, mem_wdata};
  endfunction

  // Scoreboard for read returns
  always @(negedge clk) begin
    if (tx_valid) begin
      if (exp_tx_q.size() == 0) check("tx_unexpected", 64'd1, 64'd0);
      else check("tx_data", {56'd0, tx_data}, {56'd0, exp_tx_q.pop_front()});
    end
    if (host_rvalid) begin
      if (exp_host_q.size() == 0) check("host_rvalid_unexpected", 64'd1, 64'd0);
      else check("host_rdata", {56'd0, host_rdata}, {56'd0, exp_host_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_rx(input logic [1:0] cmd, input logic [7:0] data);
    rx_data  = {cmd, data};
    rx_valid = 1'b1;
    tick();
  endtask

  task automatic host_set(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = addr;
    host_wdata = wdata;
  endtask

  task automatic wait_gnt(output int waited);
    waited = 0;
    while (!host_gnt && waited < 20) begin
      tick();
      waited++;
    end
    if (!host_gnt) check("gnt_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  int w;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    ticks(3);
    rst = 1'b0;
    check("reset_outs", all_outs(), 64'd0);
    ticks(2);

    // SPI write 0xA5 to 0x3C then read it back; tx_valid at T+4
    send_rx(2'b00, 8'h3C);
    send_rx(2'b01, 8'hA5);
    send_rx(2'b10, 8'h3C);
    exp_tx_q.push_back(8'hA5);
    send_rx(2'b11, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) tick();
      check($sformatf("spi_rd_lat_T%0d", k), {63'd0, tx_valid}, {63'd0, (k == 4)});
    end
    ticks(2);
    check("ram_3c_a5", {56'd0, ram[8'h3C]}, 64'h A5);

    // Host write 0x10 <- 0x5A, then read it
    host_set(1'b1, 8'h10, 8'h5A);
    tick();
    check("host_wr_gnt", {63'd0, host_gnt}, 64'd1);
    host_req = 1'b0;
    tick();
    host_set(1'b0, 8'h10, 8'h00);
    exp_host_q.push_back(8'h5A);
    tick();
    check("host_rd_gnt", {63'd0, host_gnt}, 64'd1);
    host_req = 1'b0;
    tick();
    check("host_rvalid_g1", {63'd0, host_rvalid}, 64'd0);
    tick();
    check("host_rvalid_g2", {63'd0, host_rvalid}, 64'd1);
    ticks(2);

    // Contention 1: last_owner is HOST, SPI goes first
    exp_tx_q.push_back(8'hA5);
    send_rx(2'b11, 8'h00);
    host_set(1'b0, 8'h10, 8'h00);
    exp_host_q.push_back(8'h5A);
    tick();
    check("c1_spi_first", {60'd0, host_gnt, mem_en, mem_we, 1'b0} | {48'd0, 8'h00, mem_addr} << 4,
          {60'd0, 4'b0100} | {48'd0, 8'h00, 8'h3C} << 4);
    wait_gnt(w);
    check("c1_host_wait", 64'(w), 64'd3);
    host_req = 1'b0;
    ticks(4);

    // Lone SPI write so SPI becomes last_owner
    send_rx(2'b01, 8'h77);
    ticks(3);
    check("ram_3c_77", {56'd0, ram[8'h3C]}, 64'h77);

    // Contention 2: last_owner is SPI, host goes first
    exp_tx_q.push_back(8'h77);
    send_rx(2'b11, 8'h00);
    host_set(1'b1, 8'h11, 8'h99);
    tick();
    check("c2_host_first", {45'd0, host_gnt, mem_en, mem_we, mem_addr, mem_wdata},
          {45'd0, 3'b111, 8'h11, 8'h99});
    host_req = 1'b0;
    ticks(6);
    check("ram_11_99", {56'd0, ram[8'h11]}, 64'h99);
    check("exp_tx_drained_c2", 64'(exp_tx_q.size()), 64'd0);

    // Lone host write so HOST becomes last_owner
    host_set(1'b1, 8'h12, 8'h34);
    tick();
    check("host_wr2_gnt", {63'd0, host_gnt}, 64'd1);
    host_req = 1'b0;
    ticks(2);

    // Overflow: host holds req, two back-to-back 01 commands
    send_rx(2'b00, 8'h50);
    check("ovf_clear_before", {63'd0, spi_ovf}, 64'd0);
    host_set(1'b1, 8'h60, 8'h11);
    send_rx(2'b01, 8'hAA);
    send_rx(2'b01, 8'hBB);
    check("ovf_set", {63'd0, spi_ovf}, 64'd1);
    wait_gnt(w);
    host_req = 1'b0;
    ticks(3);
    check("ovf_ram_50", {56'd0, ram[8'h50]}, 64'hAA);
    check("ovf_ram_60", {56'd0, ram[8'h60]}, 64'h11);
    check("ovf_sticky", {63'd0, spi_ovf}, 64'd1);

    // Address snapshot: queued write keeps 0x20 although 0x40 arrives later
    exp_host_q.push_back(8'h00);
    exp_host_q.push_back(8'h00);
    host_set(1'b0, 8'h61, 8'h00);
    send_rx(2'b00, 8'h20);
    send_rx(2'b01, 8'hC3);
    send_rx(2'b00, 8'h40);
    wait_gnt(w);
    host_req = 1'b0;
    ticks(4);
    check("snap_ram_20", {56'd0, ram[8'h20]}, 64'hC3);
    check("snap_ram_40", {56'd0, ram[8'h40]}, 64'h00);
    check("exp_host_drained", 64'(exp_host_q.size()), 64'd0);

    // Reset during RESP of an SPI read
    send_rx(2'b11, 8'h00);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_outs", all_outs(), 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rst_quiet_%0d", k), {62'd0, tx_valid, mem_en}, 64'd0);
    end

    check("exp_tx_drained", 64'(exp_tx_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
